// File: rtl/cmd_issue_fifo_if.sv
// Command types shared by the scheduler, the issue FIFO and the main command FSM,
// plus the producer/consumer handshake bundle around the FIFO.
package cmd_issue_fifo_pkg;

    typedef enum logic [3:0] {
        ATCMD_NOP       = 4'd0,
        ATCMD_ACTIVE    = 4'd1,
        ATCMD_READ      = 4'd2,
        ATCMD_WRITE     = 4'd3,
        ATCMD_PRECHARGE = 4'd4,
        ATCMD_REFRESH   = 4'd5
    } sch_cmd_t;

    typedef struct packed {
        sch_cmd_t    command;
        logic [15:0] row;
        logic [9:0]  col;
        logic [2:0]  bank;
    } issue_fifo_cmd_in_t;

endpackage

interface cmd_issue_fifo_if;

    logic                                  in_valid;
    cmd_issue_fifo_pkg::issue_fifo_cmd_in_t in_cmd;
    logic                                  in_ready;
    logic                                  out_valid;
    cmd_issue_fifo_pkg::issue_fifo_cmd_in_t out_cmd;
    logic                                  out_ready;

    // master: scheduler on the write side and FSM on the read side
    modport master (
        output in_valid, in_cmd, out_ready,
        input  in_ready, out_valid, out_cmd
    );

    modport slave (
        input  in_valid, in_cmd, out_ready,
        output in_ready, out_valid, out_cmd
    );

endinterface

// File: rtl/cmd_issue_fifo.sv
// Issue FIFO between bank scheduler and main command FSM; NOPs are absorbed at the input.
// Optional almost_full output is built when CMD_ISSUE_FIFO_AF_EN is defined.
module cmd_issue_fifo
    import cmd_issue_fifo_pkg::*;
#(
    parameter int DEPTH     = 8,
    parameter int PTR_W     = $clog2(DEPTH)
`ifdef CMD_ISSUE_FIFO_AF_EN
   ,parameter int AF_THRESH = 6
`endif
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    cmd_issue_fifo_if.slave   bus,
    output logic [PTR_W:0]    count,
    output logic              empty,
    output logic              full
`ifdef CMD_ISSUE_FIFO_AF_EN
   ,output logic              almost_full
`endif
);

    localparam logic [PTR_W:0]   FULL_CNT = DEPTH[PTR_W:0];
    localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W+1)'(1);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

    issue_fifo_cmd_in_t mem [DEPTH];

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   cnt_nxt;
    logic             accept;
    logic             push;
    logic             pop;

    assign empty = (count == '0);
    assign full  = (count == FULL_CNT);

    // in_ready depends only on registered state, so a pop never frees a slot in the same cycle
    assign bus.in_ready  = !full;
    assign bus.out_valid = !empty;
    assign bus.out_cmd   = empty ? '0 : mem[rd_ptr];

    assign accept = bus.in_valid && bus.in_ready;
    assign push   = accept && (bus.in_cmd.command != ATCMD_NOP);
    assign pop    = bus.out_valid && bus.out_ready;

    always_comb begin
        cnt_nxt = count;
        if (flush)
            cnt_nxt = '0;
        else if (push && !pop)
            cnt_nxt = count + CNT_ONE;
        else if (!push && pop)
            cnt_nxt = count - CNT_ONE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            count <= cnt_nxt;
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + PTR_ONE;
                if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
            end
        end
    end

    // Storage needs no reset: the head is masked to all-zero (NOP) whenever empty
    always_ff @(posedge clk) begin
        if (push && !flush)
            mem[wr_ptr] <= bus.in_cmd;
    end

`ifdef CMD_ISSUE_FIFO_AF_EN
    localparam logic [PTR_W:0] AF_LVL = AF_THRESH[PTR_W:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            almost_full <= 1'b0;
        else
            almost_full <= (cnt_nxt >= AF_LVL);
    end
`endif

    a_count_bound: assert property (@(posedge clk) disable iff (!rst_n) count <= FULL_CNT);
    a_no_pop_empty: assert property (@(posedge clk) disable iff (!rst_n) pop |-> !empty);

endmodule
